// File: rtl/instr_encode_loader.sv
// Packs instruction fields into 32-bit words and streams them into instruction memory.
// Optional LOADER_CHECKSUM_EN adds a running XOR checksum of completed writes.
module instr_encode_loader #(
  parameter int ADDR_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   prog_len,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        opcode,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs,
  input  logic [4:0]        rt,
  input  logic [11:0]       imm,
  output logic              imem_we,
  input  logic              imem_ready,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              busy,
  output logic              done,
`ifdef LOADER_CHECKSUM_EN
  output logic [31:0]       checksum,
`endif
  output logic [ADDR_W:0]   words_written
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = ADDR_W + 1;
  localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;

  state_t state, state_next;

  logic [CNT_W-1:0] len_q;
  logic [CNT_W-1:0] accepted;
  logic [31:0]      fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   count;
  logic             fifo_full, fifo_empty;
  logic             push, pop, complete, start_go;
  logic [31:0]      packed_word;

  assign packed_word = {opcode, rd, rs, rt, imm};
  assign fifo_full   = (count == DEPTH_CNT);
  assign fifo_empty  = (count == '0);
  assign start_go    = (state == IDLE) && start;
  assign push        = in_valid && in_ready;
  assign complete    = imem_we && imem_ready;
  // The output register takes a new word whenever it is free or being drained this cycle.
  assign pop         = !fifo_empty && (!imem_we || imem_ready);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = (prog_len == '0) ? DONE : LOAD;
      LOAD:    if (accepted == len_q) state_next = DRAIN;
      DRAIN:   if (fifo_empty && !imem_we && (words_written == len_q)) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state == LOAD) && !fifo_full && (accepted < len_q);
    busy     = (state == LOAD) || (state == DRAIN);
    done     = (state == DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      len_q         <= '0;
      accepted      <= '0;
      words_written <= '0;
    end else if (start_go) begin
      len_q         <= prog_len;
      accepted      <= '0;
      words_written <= '0;
    end else begin
      if (push)     accepted      <= accepted + CNT_W'(1);
      if (complete) words_written <= words_written + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= packed_word;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + (PTR_W + 1)'(1);
        2'b01:   count <= count - (PTR_W + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  // imem_addr always holds the address of the pending or next write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
    end else begin
      if (start_go)      imem_addr <= base_addr;
      else if (complete) imem_addr <= imem_addr + ADDR_W'(1);
      if (pop) begin
        imem_we    <= 1'b1;
        imem_wdata <= fifo_mem[rd_ptr];
      end else if (complete) begin
        imem_we <= 1'b0;
      end
    end
  end

`ifdef LOADER_CHECKSUM_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)         checksum <= '0;
    else if (start_go) checksum <= '0;
    else if (complete) checksum <= checksum ^ imem_wdata;
  end
`endif

endmodule

// File: tb/tb_instr_encode_loader.sv
// Directed self-checking bench for instr_encode_loader with hand-computed instruction words.
module tb_instr_encode_loader;

  logic        clk;
  logic        reset;
  logic        start;
  logic [7:0]  base_addr;
  logic [8:0]  prog_len;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  opcode, rd, rs, rt;
  logic [11:0] imm;
  logic        imem_we;
  logic        imem_ready;
  logic [7:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic        busy;
  logic        done;
  logic [8:0]  words_written;
`ifdef LOADER_CHECKSUM_EN
  logic [31:0] checksum;
`endif

  instr_encode_loader #(.ADDR_W(8), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .prog_len(prog_len),
    .in_valid(in_valid), .in_ready(in_ready), .opcode(opcode), .rd(rd), .rs(rs), .rt(rt),
    .imm(imm), .imem_we(imem_we), .imem_ready(imem_ready), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .busy(busy), .done(done),
`ifdef LOADER_CHECKSUM_EN
    .checksum(checksum),
`endif
    .words_written(words_written)
  );

  typedef struct {
    logic [4:0]  op, rd, rs, rt;
    logic [11:0] imm;
    logic [31:0] word;
  } vec_t;

  vec_t        vecs [8];
  int          vectors = 0;
  int          miscompares = 0;
  int          accept_count = 0;
  int          done_cnt = 0;
  int          rdy_seen = 0;
  logic [7:0]  wr_addr_q [$];
  logic [31:0] wr_data_q [$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Observes the write port and status between edges, after the drivers have settled.
  always @(negedge clk) begin
    #3;
    if (imem_we && imem_ready && !reset) begin
      wr_addr_q.push_back(imem_addr);
      wr_data_q.push_back(imem_wdata);
    end
    if (done) done_cnt++;
    if (in_ready) rdy_seen++;
  end

  task automatic clearObs();
    wr_addr_q.delete();
    wr_data_q.delete();
    done_cnt = 0;
    rdy_seen = 0;
  endtask

  task automatic startLoad(input logic [7:0] b, input logic [8:0] l);
    start = 1'b1;
    base_addr = b;
    prog_len = l;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic applyStimulus(input int first, input int n);
    int t;
    accept_count = 0;
    t = 0;
    while (accept_count < n && t < 500 && !reset) begin
      opcode = vecs[first + accept_count].op;
      rd     = vecs[first + accept_count].rd;
      rs     = vecs[first + accept_count].rs;
      rt     = vecs[first + accept_count].rt;
      imm    = vecs[first + accept_count].imm;
      in_valid = 1'b1;
      #1;
      if (in_ready) accept_count++;
      @(negedge clk);
      t++;
    end
    in_valid = 1'b0;
    if (t >= 500) checkOutput("accept_timeout", accept_count, n);
  endtask

  task automatic waitDone(input string tag);
    int t;
    for (t = 0; t < 500; t++) begin
      #1;
      if (done) break;
      @(negedge clk);
    end
    if (t >= 500) checkOutput(tag, 0, 1);
    repeat (3) @(negedge clk);
  endtask

  task automatic checkWrites(input string tag, input logic [7:0] b, input int first, input int n);
    logic [7:0] a;
    checkOutput({tag, "_count"}, wr_addr_q.size(), n);
    for (int i = 0; i < n && i < wr_addr_q.size(); i++) begin
      a = b + 8'(i);
      checkOutput($sformatf("%s_addr%0d", tag, i), wr_addr_q[i], a);
      checkOutput($sformatf("%s_data%0d", tag, i), wr_data_q[i], vecs[first + i].word);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0]  hold_addr;
    logic [31:0] hold_data;
    logic        stable;
    int          t;

    vecs[0] = '{5'h01, 5'h02, 5'h03, 5'h04, 12'h005, 32'h08864005};
    vecs[1] = '{5'h1F, 5'h00, 5'h1F, 5'h00, 12'hABC, 32'hF83E0ABC};
    vecs[2] = '{5'h00, 5'h1F, 5'h00, 5'h1F, 12'hFFF, 32'h07C1FFFF};
    vecs[3] = '{5'h10, 5'h01, 5'h02, 5'h03, 12'h123, 32'h80443123};
    vecs[4] = '{5'h05, 5'h0A, 5'h15, 5'h1B, 12'h7E1, 32'h2AABB7E1};
    vecs[5] = '{5'h1F, 5'h1F, 5'h1F, 5'h1F, 12'hFFF, 32'hFFFFFFFF};
    vecs[6] = '{5'h00, 5'h00, 5'h00, 5'h00, 12'h000, 32'h00000000};
    vecs[7] = '{5'h02, 5'h04, 5'h08, 5'h10, 12'h800, 32'h11110800};

    reset = 1'b1; start = 1'b0; base_addr = '0; prog_len = '0; in_valid = 1'b0;
    opcode = '0; rd = '0; rs = '0; rt = '0; imm = '0; imem_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checkOutput("rst_we", imem_we, 0);
    checkOutput("rst_addr", imem_addr, 0);
    checkOutput("rst_wdata", imem_wdata, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_ready", in_ready, 0);
    checkOutput("rst_ww", words_written, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Single word: latency of two cycles from acceptance to the write strobe.
    clearObs();
    startLoad(8'h10, 9'd1);
    opcode = 5'h01; rd = 5'h02; rs = 5'h03; rt = 5'h04; imm = 12'h005;
    in_valid = 1'b1;
    #1;
    checkOutput("t1_ready", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    checkOutput("t1_we_n1", imem_we, 0);
    @(negedge clk);
    #1;
    checkOutput("t1_we_n2", imem_we, 1);
    checkOutput("t1_addr", imem_addr, 8'h10);
    checkOutput("t1_data", imem_wdata, 32'h08864005);
    waitDone("t1_done_timeout");
    checkOutput("t1_ww", words_written, 1);
    checkOutput("t1_done_cnt", done_cnt, 1);
    checkWrites("t1", 8'h10, 0, 1);

    // Field extremes plus a start pulse during LOAD that must be ignored.
    clearObs();
    startLoad(8'h20, 9'd2);
    start = 1'b1; base_addr = 8'h77; prog_len = 9'd5;
    @(negedge clk);
    start = 1'b0;
    applyStimulus(0, 2);
    waitDone("t2_done_timeout");
    checkWrites("t2", 8'h20, 0, 2);
    checkOutput("t2_ww", words_written, 2);
    checkOutput("t2_done_cnt", done_cnt, 1);
`ifdef LOADER_CHECKSUM_EN
    checkOutput("t2_checksum", checksum, 32'hF0B84AB9);
`endif

    // Backpressure: imem stalls for 10 cycles while the bench keeps offering tuples.
    clearObs();
    imem_ready = 1'b0;
    startLoad(8'h40, 9'd8);
    stable = 1'b1;
    hold_addr = '0;
    hold_data = '0;
    fork
      applyStimulus(0, 8);
      begin
        for (int c = 0; c < 10; c++) begin
          @(negedge clk);
          #2;
          if (c == 4) begin
            hold_addr = imem_addr;
            hold_data = imem_wdata;
          end else if (c > 4) begin
            if (!imem_we || imem_addr !== hold_addr || imem_wdata !== hold_data) stable = 1'b0;
          end
        end
        checkOutput("bp_accepts", accept_count, 5);
        checkOutput("bp_ready_low", in_ready, 0);
        checkOutput("bp_we_held", imem_we, 1);
        checkOutput("bp_stable", stable, 1);
        checkOutput("bp_hold_data", hold_data, 32'h08864005);
        imem_ready = 1'b1;
      end
    join
    waitDone("bp_done_timeout");
    checkWrites("bp", 8'h40, 0, 8);
    checkOutput("bp_ww", words_written, 8);
    checkOutput("bp_done_cnt", done_cnt, 1);

    // Address wraps modulo 256.
    clearObs();
    startLoad(8'hFE, 9'd3);
    applyStimulus(2, 3);
    waitDone("wrap_done_timeout");
    checkWrites("wrap", 8'hFE, 2, 3);

    // Zero-length load: done only, no handshake, no writes.
    clearObs();
    startLoad(8'h00, 9'd0);
    waitDone("zero_done_timeout");
    checkOutput("zero_done_cnt", done_cnt, 1);
    checkOutput("zero_writes", wr_addr_q.size(), 0);
    checkOutput("zero_ready_seen", rdy_seen, 0);
    checkOutput("zero_ww", words_written, 0);

    // Reset after two completed writes of a six-word load.
    clearObs();
    startLoad(8'h30, 9'd6);
    fork
      applyStimulus(0, 6);
      begin
        for (t = 0; t < 300; t++) begin
          @(negedge clk);
          #2;
          if (words_written == 9'd2) break;
        end
        if (t >= 300) checkOutput("mid_rst_timeout", words_written, 2);
        reset = 1'b1;
        #1;
        checkOutput("mid_rst_we", imem_we, 0);
        checkOutput("mid_rst_busy", busy, 0);
        checkOutput("mid_rst_ww", words_written, 0);
        checkOutput("mid_rst_ready", in_ready, 0);
      end
    join
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("mid_rst_writes", wr_addr_q.size(), 2);
    repeat (3) @(negedge clk);
    checkOutput("mid_rst_quiet", wr_addr_q.size(), 2);
    clearObs();
    startLoad(8'h50, 9'd1);
    applyStimulus(5, 1);
    waitDone("post_rst_done_timeout");
    checkWrites("post_rst", 8'h50, 5, 1);
    checkOutput("post_rst_ww", words_written, 1);
    checkOutput("post_rst_done_cnt", done_cnt, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
